// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Purpose : Bundles the pipeline-hazard signals exchanged between the
//           pipeline datapath and the hazard controller.
// Signals :
//   IF_IDRegRn, IF_IDRegRm  [4:0]  source registers of the instruction in ID
//   ID_EXRegRd              [4:0]  destination register of the instruction in EX
//   ID_EXmemRead                   instruction in EX is a load
//   PCSrc                          taken branch resolved in MEM
//   dmem_req, dmem_ready           data-memory access handshake (MEM stage)
//   PCWrite, IF_IDWrite            PC / IF-ID write enables
//   ID_EXbubble                    zero the ID/EX control fields
//   IF_IDflush, ID_EXflush,
//   EX_MEMflush                    clear the named pipeline register
//   freeze                         every pipeline register holds
//   halted                         sticky memory-timeout error
//   lu_cnt, flush_cnt, wait_cnt    performance counters [CNT_W-1:0]
// Modports: master = pipeline side (drives the inputs), slave = controller.
// ----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_IDRegRn;
    logic [4:0]       IF_IDRegRm;
    logic [4:0]       ID_EXRegRd;
    logic             ID_EXmemRead;
    logic             PCSrc;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IF_IDWrite;
    logic             ID_EXbubble;
    logic             IF_IDflush;
    logic             ID_EXflush;
    logic             EX_MEMflush;
    logic             freeze;
    logic             halted;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output IF_IDRegRn, IF_IDRegRm, ID_EXRegRd, ID_EXmemRead,
               PCSrc, dmem_req, dmem_ready,
        input  PCWrite, IF_IDWrite, ID_EXbubble,
               IF_IDflush, ID_EXflush, EX_MEMflush,
               freeze, halted, lu_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  IF_IDRegRn, IF_IDRegRm, ID_EXRegRd, ID_EXmemRead,
               PCSrc, dmem_req, dmem_ready,
        output PCWrite, IF_IDWrite, ID_EXbubble,
               IF_IDflush, ID_EXflush, EX_MEMflush,
               freeze, halted, lu_cnt, flush_cnt, wait_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Purpose : Pipeline hazard controller. Detects load-use hazards (stall +
//           bubble), taken-branch flushes, and data-memory wait states
//           (global freeze), with a watchdog that latches a sticky error
//           when memory stalls longer than TIMEOUT cycles. Three saturating
//           performance counters track stalls, flushes and wait cycles.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    hazard_ctrl_if.slave (all pipeline/hazard signals)
// Parameters:
//   TIMEOUT  max consecutive memory-wait cycles before the error state
//   CNT_W    width of each performance counter
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // One spare bit so the counter can always represent TIMEOUT itself.
    localparam int               WAIT_W    = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_lu_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic w_load_use;
    logic w_freeze;
    logic w_lu_cyc;
    logic w_flush_cyc;

    // Register 31 is the hard-wired zero register, so a load to it never
    // creates a real dependency.
    assign w_load_use = bus.ID_EXmemRead && (bus.ID_EXRegRd != 5'd31) &&
                        ((bus.ID_EXRegRd == bus.IF_IDRegRn) ||
                         (bus.ID_EXRegRd == bus.IF_IDRegRm));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ready) begin
                    w_next_state = ST_RUN;
                end else if (r_wait == TIMEOUT_V) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_RUN;
        endcase
    end

    // Wait-cycle counter: 1 on entry to WAIT, +1 per WAIT cycle, 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state == ST_RUN && w_next_state == ST_WAIT) begin
            r_wait <= WAIT_W'(1);
        end else if (r_state == ST_WAIT && w_next_state == ST_WAIT) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (Mealy). Priority: freeze > branch flush > load-use.
    // A reset cycle presents the plain "run" outputs regardless of the
    // registered state, since the state is about to be forced to RUN.
    // ------------------------------------------------------------------
    always_comb begin
        w_freeze        = 1'b0;
        w_lu_cyc        = 1'b0;
        w_flush_cyc     = 1'b0;
        bus.PCWrite     = 1'b1;
        bus.IF_IDWrite  = 1'b1;
        bus.ID_EXbubble = 1'b0;
        bus.IF_IDflush  = 1'b0;
        bus.ID_EXflush  = 1'b0;
        bus.EX_MEMflush = 1'b0;
        bus.halted      = 1'b0;

        if (!reset) begin
            unique case (r_state)
                ST_RUN:  w_freeze = bus.dmem_req && !bus.dmem_ready;
                ST_WAIT: w_freeze = !bus.dmem_ready;
                ST_ERR:  w_freeze = 1'b1;
                default: w_freeze = 1'b0;
            endcase
            bus.halted = (r_state == ST_ERR);

            if (w_freeze) begin
                bus.PCWrite    = 1'b0;
                bus.IF_IDWrite = 1'b0;
            end else if (bus.PCSrc) begin
                w_flush_cyc     = 1'b1;
                bus.IF_IDflush  = 1'b1;
                bus.ID_EXflush  = 1'b1;
                bus.EX_MEMflush = 1'b1;
            end else if (w_load_use) begin
                w_lu_cyc        = 1'b1;
                bus.PCWrite     = 1'b0;
                bus.IF_IDWrite  = 1'b0;
                bus.ID_EXbubble = 1'b1;
            end
        end
    end

    assign bus.freeze = w_freeze;

    // ------------------------------------------------------------------
    // Saturating performance counters (registered outputs only).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lu_cnt    <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_lu_cyc && r_lu_cnt != CNT_MAX) begin
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            end
            if (w_flush_cyc && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_freeze && r_state != ST_ERR && r_wait_cnt != CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.lu_cnt    = r_lu_cnt;
    assign bus.flush_cnt = r_flush_cnt;
    assign bus.wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Purpose : Directed self-checking bench for hazard_ctrl (TIMEOUT=15,
//           CNT_W=16). Inputs change 1 time unit after a rising edge and
//           outputs are sampled 1 unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.CNT_W(16)) bus ();

    hazard_ctrl #(
        .TIMEOUT (15),
        .CNT_W   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every 1-bit control output against one expected vector.
    task automatic check_ctl(input string tag,
                             input logic pcw, input logic ifw,
                             input logic bub, input logic fl,
                             input logic frz, input logic hlt);
        check({tag, ".PCWrite"},     32'(bus.PCWrite),     32'(pcw));
        check({tag, ".IF_IDWrite"},  32'(bus.IF_IDWrite),  32'(ifw));
        check({tag, ".ID_EXbubble"}, 32'(bus.ID_EXbubble), 32'(bub));
        check({tag, ".IF_IDflush"},  32'(bus.IF_IDflush),  32'(fl));
        check({tag, ".ID_EXflush"},  32'(bus.ID_EXflush),  32'(fl));
        check({tag, ".EX_MEMflush"}, 32'(bus.EX_MEMflush), 32'(fl));
        check({tag, ".freeze"},      32'(bus.freeze),      32'(frz));
        check({tag, ".halted"},      32'(bus.halted),      32'(hlt));
    endtask

    task automatic check_cnt(input string tag, input int lu, input int fl,
                             input int wt);
        check({tag, ".lu_cnt"},    32'(bus.lu_cnt),    32'(lu));
        check({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(fl));
        check({tag, ".wait_cnt"},  32'(bus.wait_cnt),  32'(wt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic mr, input logic [4:0] rd,
                            input logic [4:0] rn, input logic [4:0] rm,
                            input logic pcsrc);
        bus.ID_EXmemRead = mr;
        bus.ID_EXRegRd   = rd;
        bus.IF_IDRegRn   = rn;
        bus.IF_IDRegRm   = rm;
        bus.PCSrc        = pcsrc;
    endtask

    task automatic set_mem(input logic req, input logic rdy);
        bus.dmem_req   = req;
        bus.dmem_ready = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_mem(1'b0, 1'b0);
        tick();

        // Reset cycle with a branch + load-use + memory stall all present:
        // outputs must still be the plain run values.
        set_pipe(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        set_mem(1'b1, 1'b0);
        #1;
        check_ctl("rst_cycle", 1, 1, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_mem(1'b0, 1'b0);
        #1;
        check_ctl("idle", 1, 1, 0, 0, 0, 0);
        check_cnt("after_rst", 0, 0, 0);

        // Branch flush beats a coincident load-use.
        set_pipe(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        #1;
        check_ctl("flush_vs_lu", 1, 1, 0, 1, 0, 0);
        tick();
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_cnt("flush_cnt1", 0, 1, 0);

        // Load-use via Rm.
        set_pipe(1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
        #1;
        check_ctl("lu_rm", 0, 0, 1, 0, 0, 0);
        tick();
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_ctl("lu_done", 1, 1, 0, 0, 0, 0);
        check_cnt("lu_cnt1", 1, 1, 0);

        // Load-use via Rn.
        set_pipe(1'b1, 5'd7, 5'd7, 5'd3, 1'b0);
        #1;
        check_ctl("lu_rn", 0, 0, 1, 0, 0, 0);
        tick();

        // Destination r31 never stalls.
        set_pipe(1'b1, 5'd31, 5'd31, 5'd31, 1'b0);
        #1;
        check_ctl("lu_r31", 1, 1, 0, 0, 0, 0);
        tick();

        // Register match without a load never stalls.
        set_pipe(1'b0, 5'd9, 5'd9, 5'd9, 1'b0);
        #1;
        check_ctl("no_load", 1, 1, 0, 0, 0, 0);
        tick();
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_cnt("lu_cnt2", 2, 1, 0);

        // Memory wait: 3 cycles not ready, then ready. First cycle also
        // carries a branch and a load-use that the freeze must mask.
        set_mem(1'b1, 1'b0);
        set_pipe(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        #1;
        check_ctl("wait_c1", 0, 0, 0, 0, 1, 0);
        tick();
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_ctl("wait_c2", 0, 0, 0, 0, 1, 0);
        tick();
        #1;
        check_ctl("wait_c3", 0, 0, 0, 0, 1, 0);
        tick();
        set_mem(1'b1, 1'b1);
        #1;
        check_ctl("wait_rdy", 1, 1, 0, 0, 0, 0);
        tick();
        // Idle memory with ready low: no freeze means back in RUN.
        set_mem(1'b0, 1'b0);
        #1;
        check_ctl("wait_back_run", 1, 1, 0, 0, 0, 0);
        check_cnt("wait_cnt3", 2, 1, 3);

        // Zero-wait access: no freeze, no state change.
        set_mem(1'b1, 1'b1);
        #1;
        check_ctl("zero_wait", 1, 1, 0, 0, 0, 0);
        tick();
        set_mem(1'b0, 1'b0);
        #1;
        check_ctl("zero_wait_after", 1, 1, 0, 0, 0, 0);
        check_cnt("zero_wait_cnt", 2, 1, 3);

        // Timeout: ready low for 16 cycles -> ERR on the 16th edge.
        set_mem(1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            #1;
            check_ctl($sformatf("to_c%0d", i), 0, 0, 0, 0, 1, 0);
            tick();
        end
        #1;
        check_ctl("to_c16", 0, 0, 0, 0, 1, 0);
        tick();
        #1;
        check_ctl("err_entry", 0, 0, 0, 0, 1, 1);
        check_cnt("err_cnt", 2, 1, 19);
        // ERR ignores ready, branch and load-use, and stops wait_cnt.
        set_mem(1'b1, 1'b1);
        set_pipe(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        tick();
        tick();
        #1;
        check_ctl("err_hold", 0, 0, 0, 0, 1, 1);
        check_cnt("err_hold_cnt", 2, 1, 19);

        // Reset out of ERR.
        reset = 1'b1;
        set_mem(1'b1, 1'b0);
        #1;
        check_ctl("rst_from_err", 1, 1, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        set_pipe(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_mem(1'b0, 1'b0);
        #1;
        check_ctl("after_err_rst", 1, 1, 0, 0, 0, 0);
        check_cnt("after_err_rst", 0, 0, 0);

        // Saturation of lu_cnt.
        set_pipe(1'b1, 5'd12, 5'd12, 5'd1, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        check_cnt("lu_fffe", 16'hFFFE, 0, 0);
        tick();
        check_cnt("lu_ffff", 16'hFFFF, 0, 0);
        #1;
        check_ctl("lu_at_sat", 0, 0, 1, 0, 0, 0);
        tick();
        check_cnt("lu_sat_hold", 16'hFFFF, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
